// File: rtl/credential_entry_pkg.sv
// credential_entry_pkg: key codes, state encoding and helpers shared by credential_entry.
package credential_entry_pkg;
  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_ENT = 4'hB;
  localparam logic [3:0] KEY_CAN = 4'hC;
  localparam int ACC_MAX = 4095;
  typedef enum logic [2:0] {IDLE, ACC_ENTRY, PIN_ENTRY, WAIT_AUTH, AUTHED, LOCKED} state_t;
  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction
endpackage

// File: rtl/credential_entry_if.sv
// credential_entry_if: keypad, authenticator and credential signals of credential_entry.
interface credential_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        auth_done;
  logic        auth_ok;
  logic [11:0] acc_number;
  logic [3:0]  pin;
  logic        cred_valid;
  logic        session_active;
  logic        logout;
  logic        error;
  logic        locked;
  logic [1:0]  attempts;
  modport master (
    output key_valid, key_code, auth_done, auth_ok,
    input  acc_number, pin, cred_valid, session_active, logout, error, locked, attempts
  );
  modport slave (
    input  key_valid, key_code, auth_done, auth_ok,
    output acc_number, pin, cred_valid, session_active, logout, error, locked, attempts
  );
endinterface

// File: rtl/credential_entry_digit_accumulator.sv
// digit_accumulator: decimal account-number accumulator (max 4 digits) with 12-bit range check.
module digit_accumulator
  import credential_entry_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [3:0]  i_digit,
  output logic [11:0] o_acc,
  output logic        o_ok
);
  logic [13:0] r_work;
  logic [2:0]  r_cnt;
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_work <= '0;
      r_cnt  <= '0;
    end else if (i_en && r_cnt != 3'd4) begin
      r_work <= r_work * 14'd10 + {10'd0, i_digit};
      r_cnt  <= r_cnt + 3'd1;
    end
  end
  assign o_acc = r_work[11:0];
  assign o_ok  = r_cnt == 3'd4 && r_work <= 14'(ACC_MAX);
endmodule

// File: rtl/credential_entry.sv
// credential_entry: account/PIN keypad entry FSM with inactivity timeout.
// Define CREDENTIAL_LOCKOUT_EN to lock out after MAX_ATTEMPTS consecutive failed PIN checks.
module credential_entry
  import credential_entry_pkg::*;
#(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic clk,
  input logic rst,
  credential_entry_if.slave bus
);
`ifdef CREDENTIAL_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t r_state, w_nxt;
  logic [TW-1:0] r_tmo;
  logic [11:0] r_acc, w_acc_val;
  logic [3:0] r_pin;
  logic [1:0] r_att;
  logic r_pin_set, r_cv, r_sa, r_lgo, r_err, r_lk;
  logic w_key, w_dig, w_clr, w_ent, w_can, w_timed, w_tmo, w_ok, w_lock;
  logic w_acc_en, w_acc_clr, w_ld_acc, w_ld_pin, w_pin_clr, w_err, w_lgo, w_att_inc, w_att_clr;
  digit_accumulator u_acc (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_acc_clr),
    .i_en   (w_acc_en),
    .i_digit(bus.key_code),
    .o_acc  (w_acc_val),
    .o_ok   (w_ok)
  );
  always_comb begin
    w_key   = bus.key_valid && bus.key_code <= KEY_CAN;
    w_dig   = w_key && is_digit(bus.key_code);
    w_clr   = w_key && bus.key_code == KEY_CLR;
    w_ent   = w_key && bus.key_code == KEY_ENT;
    w_can   = w_key && bus.key_code == KEY_CAN;
    w_timed = r_state inside {ACC_ENTRY, PIN_ENTRY, AUTHED};
    w_tmo   = w_timed && !w_key && r_tmo == TW'(TIMEOUT_CYCLES - 1);
    w_lock  = LOCK_EN && (int'(r_att) + 1 >= MAX_ATTEMPTS);
  end
  always_comb begin
    w_nxt     = r_state;
    w_acc_en  = 1'b0;
    w_acc_clr = 1'b0;
    w_ld_acc  = 1'b0;
    w_ld_pin  = 1'b0;
    w_pin_clr = 1'b0;
    w_err     = 1'b0;
    w_lgo     = 1'b0;
    w_att_inc = 1'b0;
    w_att_clr = 1'b0;
    case (r_state)
      IDLE: if (w_dig) begin
        w_acc_en = 1'b1;
        w_nxt    = ACC_ENTRY;
      end
      ACC_ENTRY: if (w_can || w_tmo) begin
        w_acc_clr = 1'b1;
        w_err     = w_tmo;
        w_nxt     = IDLE;
      end else if (w_dig) w_acc_en = 1'b1;
      else if (w_clr) w_acc_clr = 1'b1;
      else if (w_ent) begin
        w_acc_clr = 1'b1;
        w_ld_acc  = w_ok;
        w_err     = !w_ok;
        w_nxt     = w_ok ? PIN_ENTRY : IDLE;
      end
      PIN_ENTRY: if (w_can || w_tmo) begin
        w_err = w_tmo;
        w_nxt = IDLE;
      end else if (w_dig && !r_pin_set) w_ld_pin = 1'b1;
      else if (w_clr) w_pin_clr = 1'b1;
      else if (w_ent) begin
        w_err = !r_pin_set;
        w_nxt = r_pin_set ? WAIT_AUTH : PIN_ENTRY;
      end
      // cancel outranks a same-cycle verdict
      WAIT_AUTH: if (w_can) w_nxt = IDLE;
      else if (bus.auth_done) begin
        w_att_clr = bus.auth_ok;
        w_att_inc = !bus.auth_ok;
        w_err     = !bus.auth_ok;
        w_nxt     = bus.auth_ok ? AUTHED : w_lock ? LOCKED : PIN_ENTRY;
      end
      AUTHED: if (w_can || w_tmo) begin
        w_lgo = 1'b1;
        w_nxt = IDLE;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo     <= '0;
      r_acc     <= '0;
      r_pin     <= '0;
      r_att     <= '0;
      r_pin_set <= 1'b0;
      r_cv      <= 1'b0;
      r_sa      <= 1'b0;
      r_lgo     <= 1'b0;
      r_err     <= 1'b0;
      r_lk      <= 1'b0;
    end else begin
      r_tmo     <= (w_key || w_nxt != r_state || !w_timed) ? '0 : r_tmo + 1'b1;
      r_acc     <= w_ld_acc ? w_acc_val : r_acc;
      r_pin     <= w_ld_pin ? bus.key_code : r_pin;
      r_att     <= w_att_clr ? 2'd0 : (w_att_inc && r_att != 2'd3) ? r_att + 2'd1 : r_att;
      r_pin_set <= r_state == PIN_ENTRY && w_nxt == PIN_ENTRY && (w_ld_pin || (r_pin_set && !w_pin_clr));
      r_cv      <= w_nxt == WAIT_AUTH;
      r_sa      <= w_nxt == AUTHED;
      r_lgo     <= w_lgo;
      r_err     <= w_err;
      r_lk      <= w_nxt == LOCKED;
    end
  end
  assign bus.acc_number     = r_acc;
  assign bus.pin            = r_pin;
  assign bus.cred_valid     = r_cv;
  assign bus.session_active = r_sa;
  assign bus.logout         = r_lgo;
  assign bus.error          = r_err;
  assign bus.locked         = r_lk;
  assign bus.attempts       = r_att;
endmodule

// File: doc/credential_entry.md
CREDENTIAL_ENTRY -- requirements
Module: credential_entry

Interface
REQ-001 SHALL provide parameter MAX_ATTEMPTS, default 3, consecutive failed PIN checks before lockout.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 1000, inactivity limit in clk cycles.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; every register updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 key_valid  in  1  one-cycle strobe qualifying key_code.
REQ-007 key_code  in  4  0-9 digit, 4'hA clear, 4'hB enter, 4'hC cancel; 4'hD-4'hF ignored.
REQ-008 auth_done  in  1  one-cycle strobe from the authenticator.
REQ-009 auth_ok  in  1  authenticator verdict, sampled only when auth_done=1.
REQ-010 acc_number  out  12  assembled account number.
REQ-011 pin  out  4  assembled PIN digit.
REQ-012 cred_valid  out  1  credentials stable and presented to the authenticator.
REQ-013 session_active  out  1  user authenticated.
REQ-014 logout  out  1  one-cycle pulse on session end.
REQ-015 error  out  1  one-cycle pulse on rejected entry, timeout or failed PIN.
REQ-016 locked  out  1  lockout active.
REQ-017 attempts  out  2  failed-attempt count.

Function
REQ-018 SHALL implement states IDLE, ACC_ENTRY, PIN_ENTRY, WAIT_AUTH, AUTHED, LOCKED.
REQ-019 In IDLE/ACC_ENTRY, a digit SHALL update acc_work = acc_work*10 + digit (14-bit) and increment digit_cnt; IDLE moves to ACC_ENTRY; digits beyond the 4th SHALL be ignored.
REQ-020 Clear SHALL zero acc_work and digit_cnt in ACC_ENTRY, and clear the PIN-entered flag in PIN_ENTRY.
REQ-021 Enter in ACC_ENTRY with digit_cnt==4 and acc_work<=4095 SHALL load acc_number and go to PIN_ENTRY next cycle.
REQ-022 Enter in ACC_ENTRY otherwise SHALL pulse error, clear acc_work, and go to IDLE.
REQ-023 In PIN_ENTRY the first digit SHALL load pin; later digits SHALL be ignored.
REQ-024 Enter in PIN_ENTRY with a digit held SHALL go to WAIT_AUTH; without one it SHALL pulse error and stay.
REQ-025 cred_valid SHALL be 1 exactly while in WAIT_AUTH; acc_number and pin SHALL not change there.
REQ-026 auth_done & auth_ok in WAIT_AUTH SHALL go to AUTHED, clear attempts, and assert session_active.
REQ-027 auth_done & !auth_ok SHALL pulse error, increment attempts, and return to PIN_ENTRY keeping acc_number.
REQ-028 Cancel in ACC_ENTRY, PIN_ENTRY or WAIT_AUTH SHALL go to IDLE and clear work registers; it SHALL take precedence over a same-cycle auth_done.
REQ-029 Cancel in AUTHED SHALL pulse logout, deassert session_active, and go to IDLE; attempts SHALL stay 0.
REQ-030 The inactivity counter SHALL reset on any accepted key_valid; reaching TIMEOUT_CYCLES in ACC_ENTRY or PIN_ENTRY SHALL pulse error and go to IDLE.
REQ-031 WAIT_AUTH SHALL have no timeout; AUTHED timeout SHALL behave as cancel (logout pulse).
REQ-032 Keys other than cancel in WAIT_AUTH/AUTHED SHALL be ignored; 4'hD-4'hF SHALL be ignored everywhere.
REQ-033 Outputs SHALL be registered; a key accepted at edge N SHALL take effect at edge N.

Reset
REQ-034 rst SHALL force IDLE and zero every output and internal counter, including from LOCKED and mid-WAIT_AUTH.
REQ-035 rst SHALL take precedence over every key and auth input in the same cycle.

Configuration
REQ-036 With CREDENTIAL_LOCKOUT_EN defined, attempts reaching MAX_ATTEMPTS SHALL enter LOCKED instead of PIN_ENTRY and set locked=1.
REQ-037 LOCKED SHALL ignore all inputs until rst.
REQ-038 Without CREDENTIAL_LOCKOUT_EN, attempts SHALL saturate at 3, locked SHALL be tied to 0, and LOCKED SHALL be unreachable.

Structure
REQ-039 Shared package SHALL hold the key_code constants (KEY_CLR, KEY_ENT, KEY_CAN) and the state encoding.
REQ-040 Sub-module digit_accumulator SHALL own acc_work, digit_cnt and the range check.

Verification
REQ-041 Keys 2,1,7,5,ENT,1,ENT, then auth_done=1 with auth_ok=1 -> acc_number=2175, pin=1, cred_valid high before auth_done, then session_active=1.
REQ-042 Keys 9,9,9,9,ENT -> error pulse, state IDLE, acc_number unchanged.
REQ-043 Account 2175, then three failures (auth_ok=0) with CREDENTIAL_LOCKOUT_EN -> attempts=3, locked=1, later keys ignored; rst clears locked.
REQ-044 Keys 2,1 then 1000 idle cycles -> error pulse at cycle 1000, state IDLE.
REQ-045 Cancel and auth_done/auth_ok=1 in the same WAIT_AUTH cycle -> IDLE, session_active=0.
REQ-046 In AUTHED, cancel -> logout pulse for exactly 1 cycle and session_active=0.
